// File: rtl/demux14_buf.sv
// Buffered 1:4 demultiplexer: one valid/ready input stream is steered by in_select
// into one of four small FIFOs, and each FIFO drains through its own valid/ready port.

module demux14_buf_ch #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    cnt
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;
  logic                        pop;

  assign valid = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = valid && rdy;
  assign head  = mem[rp];

  // Storage is cleared on reset as well, so the heads read 0 until first written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

module demux14_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_select,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [4*CW-1:0]  level
);
  logic [3:0]                 full, push;
  logic [3:0][WIDTH-1:0]      head;
  logic [3:0][CW-1:0]         cnt;

  // Case form keeps an unknown select from ever reporting ready.
  always_comb begin
    in_ready = 1'b0;
    case (in_select)
      2'b00:   in_ready = !full[0];
      2'b01:   in_ready = !full[1];
      2'b10:   in_ready = !full[2];
      2'b11:   in_ready = !full[3];
      default: in_ready = 1'b0;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_ch
      assign push[k] = in_valid && in_ready && (in_select == 2'(k));
      demux14_buf_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[k]),
        .din   (in_data),
        .rdy   (out_ready[k]),
        .valid (out_valid[k]),
        .full  (full[k]),
        .head  (head[k]),
        .cnt   (cnt[k])
      );
    end
  endgenerate

  assign out1  = head[0];
  assign out2  = head[1];
  assign out3  = head[2];
  assign out4  = head[3];
  assign level = cnt;
endmodule
